// File: rtl/keypad_pkg.sv
// Shared constants, debounce state type and the (row, col) -> key code map
// for the 4x3 phone keypad.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    CONFIRM = 1'b1
  } deb_state_t;

  // Rows 0..2 carry digits 1..9; row 3 is *, 0, #.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the debounced key outputs seen by the control unit.
interface keypad_scanner_if;
  import keypad_pkg::*;

  // key_valid is a one-cycle strobe with no ready/backpressure; key is stable
  // and already holds the accepted code in the cycle key_valid is high.
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  deb_state_t deb_state;

  modport slave (
    input  row_n,
    output col_n, key, key_valid, key_held, deb_state
  );

  modport master (
    output row_n,
    input  col_n, key, key_valid, key_held, deb_state
  );

endinterface

// File: rtl/keypad_debounce.sv
// Candidate/stable-count debounce FSM and key output registers.
// Optional auto-repeat strobes are built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw,
  input  logic       scan_done,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output deb_state_t state
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  if (DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_debounce: DEBOUNCE_SCANS and REPEAT_SCANS must be >= 1");
  end

  deb_state_t    state_n;
  logic [3:0]    cand, cand_n, key_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept, valid_n, valid_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= KEY_NONE;
      cnt       <= '0;
      key       <= KEY_NONE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key       <= key_n;
      key_valid <= valid_all;
      key_held  <= (key_n != KEY_NONE);
    end
  end

  always_comb begin
    cand_n  = cand;
    cnt_n   = cnt;
    key_n   = key;
    accept  = 1'b0;
    if (scan_done) begin
      if (raw == cand) begin
        if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
      end else begin
        cand_n = raw;
        cnt_n  = CW'(1);
      end
      if (cnt_n == CNT_MAX && cand_n != key) begin
        accept = 1'b1;
        key_n  = cand_n;
      end
    end
    valid_n = accept && (key_n != KEY_NONE);
    // CONFIRM means a candidate differs from the accepted key and is counting.
    state_n = state;
    case (state)
      IDLE:    if (cand_n != key_n) state_n = CONFIRM;
      CONFIRM: if (cand_n == key_n) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);

  logic [RW-1:0] rep, rep_n;
  logic          rep_fire;

  always_ff @(posedge clk) begin
    if (rst) rep <= '0;
    else     rep <= rep_n;
  end

  always_comb begin
    rep_n    = rep;
    rep_fire = 1'b0;
    if (scan_done) begin
      if (accept || key == KEY_NONE || raw != key) begin
        rep_n = '0;
      end else if (rep == REP_LAST) begin
        rep_n    = '0;
        rep_fire = 1'b1;
      end else begin
        rep_n = rep + 1'b1;
      end
    end
  end

  assign valid_all = valid_n | rep_fire;
`else
  assign valid_all = valid_n;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row synchroniser, column dwell/rotation and
// per-scan raw key resolution feeding keypad_debounce (see KEYPAD_REPEAT_EN).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.slave   kp
);

  localparam int DW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 4) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV must be >= 4");
  end

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [1:0]    acc_hits;
  logic [3:0]    acc_code;
  logic          dwell_last, scan_done;
  logic [2:0]    col_hits, tot_hits;
  logic [3:0]    col_code, sel_code, raw;

  assign dwell_last = (dwell == DW'(SCAN_DIV - 1));
  assign scan_done  = dwell_last && (col == 2'(NUM_COLS - 1));
  assign kp.col_n   = ~(3'b001 << col);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      dwell    <= '0;
      col      <= '0;
      acc_hits <= '0;
      acc_code <= KEY_NONE;
    end else begin
      row_meta <= kp.row_n;
      row_sync <= row_meta;
      if (dwell_last) begin
        dwell <= '0;
        if (scan_done) begin
          col      <= '0;
          acc_hits <= '0;
          acc_code <= KEY_NONE;
        end else begin
          col      <= col + 2'd1;
          acc_hits <= (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
          acc_code <= sel_code;
        end
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Hits saturate at two: any multi-key or ghosted scan resolves to KEY_NONE.
  always_comb begin
    col_hits = '0;
    col_code = KEY_NONE;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_code(2'(r), col);
      end
    end
    tot_hits = {1'b0, acc_hits} + col_hits;
    sel_code = (acc_hits != 2'd0) ? acc_code : col_code;
    raw      = (tot_hits == 3'd1) ? sel_code : KEY_NONE;
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw),
    .scan_done (scan_done),
    .key       (kp.key),
    .key_valid (kp.key_valid),
    .key_held  (kp.key_held),
    .state     (kp.deb_state)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad pin model, scan-level debounce model,
// per-cycle compare and directed press/bounce/reset scenarios.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 4;
  localparam int SCAN_CYC = 3 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_SCANS   (REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Pressed keys, index = row*3 + col.
  logic [11:0] pressed = '0;
  logic [3:0]  code_tab [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                 4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    int ac;
    ac = -1;
    case (kif.col_n)
      3'b110:  ac = 0;
      3'b101:  ac = 1;
      3'b011:  ac = 2;
      default: ac = -1;
    endcase
    kif.row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (ac >= 0 && pressed[r*3+ac]) kif.row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] scan_raw(input logic [11:0] m);
    int n;
    logic [3:0] c;
    n = 0;
    c = 4'hF;
    for (int i = 0; i < 12; i++)
      if (m[i]) begin
        n++;
        c = code_tab[i];
      end
    return (n == 1) ? c : 4'hF;
  endfunction

  // Scan-level model: key follows the last DEB raw results when they agree.
  int          cyc = 0;
  int          run = 0;
  logic [3:0]  mkey = 4'hF;
  logic        mvalid = 1'b0;
  logic [3:0]  raw_q[$];
  logic [3:0]  exp_q[$];

  initial forever begin
    logic [3:0] raw;
    bit same, changed;
    @(posedge clk);
    if (rst) begin
      cyc = 0; run = 0; mkey = 4'hF; mvalid = 1'b0;
      raw_q.delete();
    end else begin
      mvalid  = 1'b0;
      changed = 1'b0;
      if (cyc % SCAN_CYC == SCAN_CYC - 1) begin
        raw = scan_raw(pressed);
        raw_q.push_back(raw);
        if (raw_q.size() > DEB) void'(raw_q.pop_front());
        same = (raw_q.size() == DEB);
        foreach (raw_q[i]) if (raw_q[i] != raw_q[0]) same = 1'b0;
        if (same && raw_q[0] != mkey) begin
          mkey    = raw_q[0];
          changed = 1'b1;
          if (mkey != 4'hF) begin
            mvalid = 1'b1;
            exp_q.push_back(mkey);
          end
        end
`ifdef KEYPAD_REPEAT_EN
        if (changed || mkey == 4'hF || raw != mkey) run = 0;
        else begin
          run++;
          if (run % REP == 0) begin
            mvalid = 1'b1;
            exp_q.push_back(mkey);
          end
        end
`endif
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    logic [2:0] exp_col;
    @(negedge clk);
    exp_col = ~(3'b001 << ((cyc % SCAN_CYC) / SCAN_DIV));
    check("col_n", kif.col_n, exp_col);
    check("key", kif.key, mkey);
    check("key_valid", kif.key_valid, mvalid);
    check("key_held", kif.key_held, mkey != 4'hF);
    if (kif.key_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pulse_code at %0t: got %0h expected no pulse", $time, kif.key);
      end else begin
        check("pulse_code", kif.key, exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic scans(input int n);
    cycles(n * SCAN_CYC);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    #1;
    do_reset();
    check("rst_col_n", kif.col_n, 3'b110);
    check("rst_key", kif.key, 4'hF);
    check("rst_valid", kif.key_valid, 1'b0);
    check("rst_held", kif.key_held, 1'b0);
    check("rst_state", kif.deb_state, IDLE);
    cycles(4); check("col1", kif.col_n, 3'b101);
    cycles(4); check("col2", kif.col_n, 3'b011);
    cycles(4); check("col0_wrap", kif.col_n, 3'b110);

    // '5' held: accepted at end of the third scan with one pulse.
    p0 = pulses;
    pressed = 12'b1 << 4;
    scans(2); check("p5_not_yet", kif.key, 4'hF);
    check("p5_confirm", kif.deb_state, CONFIRM);
    scans(1);
    check("p5_key", kif.key, 4'h5);
    check("p5_valid", kif.key_valid, 1'b1);
    check("p5_held", kif.key_held, 1'b1);
    scans(2); check("p5_pulses", pulses - p0, 1);

    // Release: key clears after three scans, no pulse.
    pressed = '0;
    scans(2); check("rel_hold", kif.key, 4'h5);
    scans(1);
    check("rel_key", kif.key, 4'hF);
    check("rel_valid", kif.key_valid, 1'b0);
    scans(1); check("rel_pulses", pulses - p0, 1);

    // Bounce on '8': two scans on, one off, four times.
    p0 = pulses;
    repeat (4) begin
      pressed = 12'b1 << 7; scans(2);
      pressed = '0;         scans(1);
    end
    scans(3);
    check("bounce_key", kif.key, 4'hF);
    check("bounce_pulses", pulses - p0, 0);

    // Multi-press '1' + '#', then release '#'.
    pressed = (12'b1 << 0) | (12'b1 << 11);
    scans(4); check("multi_key", kif.key, 4'hF);
    p0 = pulses;
    pressed = 12'b1 << 0;
    scans(3);
    check("one_key", kif.key, 4'h1);
    check("one_valid", kif.key_valid, 1'b1);
    // Direct change 1 -> 9 with no release in between.
    pressed = 12'b1 << 8;
    scans(3);
    check("nine_key", kif.key, 4'h9);
    check("nine_valid", kif.key_valid, 1'b1);
    scans(1); check("multi_pulses", pulses - p0, 2);
    pressed = '0;
    scans(4);

    // Reset while '*' is mid-debounce, key still held through reset.
    pressed = 12'b1 << 9;
    scans(2);
    do_reset();
    check("mid_rst_key", kif.key, 4'hF);
    check("mid_rst_state", kif.deb_state, IDLE);
    p0 = pulses;
    scans(2); check("star_not_yet", kif.key, 4'hF);
    scans(1);
    check("star_key", kif.key, 4'hA);
    check("star_valid", kif.key_valid, 1'b1);
    scans(1); check("star_pulses", pulses - p0, 1);
    pressed = '0;
    scans(4);

    // '0' held for 20 scans.
    p0 = pulses;
    pressed = 12'b1 << 10;
    scans(20);
    check("zero_key", kif.key, 4'h0);
`ifdef KEYPAD_REPEAT_EN
    check("zero_pulses", pulses - p0, 5);
`else
    check("zero_pulses", pulses - p0, 1);
`endif
    pressed = '0;
    scans(4);
    check("final_key", kif.key, 4'hF);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
